// File: rtl/parse_uart.sv
`default_nettype none
// ============================================================================
// Module   : parse_uart
// Purpose  : Deserialises the UART receive byte stream into one option-pricing
//            record of seven big-endian 32-bit fields and presents the complete
//            record with a one-cycle data_out_rdy strobe.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           in   1   system clock, all logic on posedge
//   rst           in   1   synchronous, active-low reset
//   data_in       in   8   received UART byte
//   data_rdy      in   1   data_in valid this cycle (one byte per high cycle)
//   option_id     out  32  field 0 of last complete record
//   sptprice      out  32  field 1, spot price
//   strike        out  32  field 2, strike price
//   rate          out  32  field 3, risk-free rate
//   volatility    out  32  field 4
//   otime         out  32  field 5, time to expiry
//   otype         out  32  field 6, option type
//   data_out_rdy  out  1   one-cycle strobe, new record on the field outputs
// ============================================================================
module parse_uart #(
  parameter int NUM_FIELDS = 7,
  parameter int FIELD_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         data_in,
  input  logic               data_rdy,
  output logic [FIELD_W-1:0] option_id,
  output logic [FIELD_W-1:0] sptprice,
  output logic [FIELD_W-1:0] strike,
  output logic [FIELD_W-1:0] rate,
  output logic [FIELD_W-1:0] volatility,
  output logic [FIELD_W-1:0] otime,
  output logic [FIELD_W-1:0] otype,
  output logic               data_out_rdy
);

  localparam int REC_W         = NUM_FIELDS * FIELD_W;
  localparam int BYTES_PER_REC = REC_W / 8;
  localparam int CNT_W         = 5;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTES_PER_REC - 1);

  logic [CNT_W-1:0]   byte_cnt;
  logic [REC_W-1:0]   staging;
  logic [REC_W-1:0]   staging_next;
  logic               last_byte;
  logic [FIELD_W-1:0] rec_q [NUM_FIELDS];

  // Bytes shift in at the LSB end, so after a full record byte 0 sits in the
  // top octet: this is exactly big-endian, fields in port order.
  assign staging_next = {staging[REC_W-9:0], data_in};
  assign last_byte    = (byte_cnt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst) begin
      byte_cnt     <= '0;
      staging      <= '0;
      data_out_rdy <= 1'b0;
      for (int i = 0; i < NUM_FIELDS; i++) begin
        rec_q[i] <= '0;
      end
    end else begin
      data_out_rdy <= 1'b0;
      if (data_rdy) begin
        staging <= staging_next;
        if (last_byte) begin
          // Load from the shifted value so the final byte is included in the
          // same edge that completes the record.
          byte_cnt     <= '0;
          data_out_rdy <= 1'b1;
          for (int i = 0; i < NUM_FIELDS; i++) begin
            rec_q[i] <= staging_next[REC_W-1-i*FIELD_W -: FIELD_W];
          end
        end else begin
          byte_cnt <= byte_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign option_id  = rec_q[0];
  assign sptprice   = rec_q[1];
  assign strike     = rec_q[2];
  assign rate       = rec_q[3];
  assign volatility = rec_q[4];
  assign otime      = rec_q[5];
  assign otype      = rec_q[6];

endmodule
`default_nettype wire

// File: tb/tb_parse_uart.sv
`default_nettype none
// ============================================================================
// Module   : tb_parse_uart
// Purpose  : Self-checking bench for parse_uart. Stimulus feeds a byte-level
//            reference model that pushes expected records into a queue; an
//            independent monitor pops and compares on every strobe and checks
//            that the field outputs hold between strobes.
// Revision : 1.0  initial release
// ============================================================================
module tb_parse_uart;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic        data_rdy = 1'b0;
  logic [31:0] option_id, sptprice, strike, rate, volatility, otime, otype;
  logic        data_out_rdy;

  int checks   = 0;
  int failures = 0;

  logic [7:0]   model_bytes [$];
  logic [223:0] exp_q [$];
  logic [223:0] cur_rec = '0;

  parse_uart dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .data_rdy     (data_rdy),
    .option_id    (option_id),
    .sptprice     (sptprice),
    .strike       (strike),
    .rate         (rate),
    .volatility   (volatility),
    .otime        (otime),
    .otype        (otype),
    .data_out_rdy (data_out_rdy)
  );

  always #5 clk = ~clk;

  // Reference model: collect bytes; every 28th byte forms a record whose
  // field f is the big-endian concatenation of bytes 4f..4f+3.
  task automatic model_step(input logic r, input logic v, input logic [7:0] b);
    logic [223:0] rec;
    logic [31:0]  fld;
    if (!r) begin
      model_bytes.delete();
    end else if (v) begin
      model_bytes.push_back(b);
      if (model_bytes.size() == 28) begin
        rec = '0;
        for (int f = 0; f < 7; f++) begin
          fld = {model_bytes[4*f], model_bytes[4*f+1],
                 model_bytes[4*f+2], model_bytes[4*f+3]};
          rec[223-32*f -: 32] = fld;
        end
        exp_q.push_back(rec);
        model_bytes.delete();
      end
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [7:0] b);
    @(negedge clk);
    rst      = r;
    data_rdy = v;
    data_in  = b;
    model_step(r, v, b);
  endtask

  task automatic send_byte(input logic [7:0] b);
    drive(1'b1, 1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 8'($urandom));
  endtask

  task automatic send_seq(input logic [7:0] start, input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      send_byte(start + 8'(i));
      if (max_gap > 0) idle($urandom_range(0, max_gap));
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Monitor: decoupled from stimulus, samples 2 time units after each posedge.
  initial begin : monitor
    logic rst_at;
    logic [223:0] act;
    forever begin
      @(posedge clk);
      rst_at = rst;
      #2;
      checks++;
      if (!rst_at) begin
        exp_q.delete();
        cur_rec = '0;
        if (data_out_rdy !== 1'b0) begin
          failures++;
          $display("FAIL reset_strobe: got %b expected 0", data_out_rdy);
        end
      end else if (exp_q.size() > 0) begin
        cur_rec = exp_q.pop_front();
        if (data_out_rdy !== 1'b1) begin
          failures++;
          $display("FAIL strobe_missing: got %b expected 1", data_out_rdy);
        end
      end else if (data_out_rdy !== 1'b0) begin
        failures++;
        $display("FAIL spurious_strobe: got %b expected 0", data_out_rdy);
      end
      act = {option_id, sptprice, strike, rate, volatility, otime, otype};
      checks++;
      if (act !== cur_rec) begin
        failures++;
        $display("FAIL fields: got %h expected %h", act, cur_rec);
      end
    end
  end

  initial begin : stimulus
    // Reset, with a byte offered during reset that must be ignored.
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'h55);
    drive(1'b0, 1'b1, 8'hAA);
    idle(2);

    // Consecutive bytes 0x01..0x1C.
    send_seq(8'h01, 28, 0);
    idle(2);
    @(negedge clk);
    check32("t1_option_id", option_id, 32'h01020304);
    check32("t1_rate",      rate,      32'h0D0E0F10);
    check32("t1_otype",     otype,     32'h191A1B1C);

    // Partial record then completion.
    send_seq(8'h01, 21, 0);
    idle(5);
    send_seq(8'h16, 7, 0);
    idle(2);

    // Random idle gaps between bytes.
    send_seq(8'h01, 28, 3);
    idle(2);

    // Back-to-back records with no gap.
    send_seq(8'h01, 28, 0);
    send_seq(8'hA0, 28, 0);
    idle(2);
    @(negedge clk);
    check32("t4_option_id", option_id, 32'hA0A1A2A3);
    check32("t4_otype",     otype,     32'hB8B9BABB);

    // Reset mid-record discards the partial record.
    send_seq(8'h40, 10, 0);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'h77);
    send_seq(8'h01, 28, 0);
    idle(2);
    @(negedge clk);
    check32("t5_sptprice", sptprice, 32'h05060708);

    // Randomised records, gaps and occasional mid-record resets.
    for (int r = 0; r < 12; r++) begin
      int n;
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 27)) : 28;
      for (int i = 0; i < n; i++) begin
        send_byte(8'($urandom));
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
      if (n != 28) drive(1'b0, $urandom_range(0, 1) == 1, 8'($urandom));
    end
    idle(4);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_records: got %0d expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
